soc_data_mem: RTL and testbench
===============================

# soc_data_mem

Data-side memory responder for the zero-riscy SoC. It answers the core's LSU request/grant/rvalid protocol with a byte-enabled word RAM and two memory-mapped status registers, `mem_flag` and `mem_result`, which the testbench monitors to detect end of program. It sits between the core's data port and the SoC top-level outputs `mem_flag`/`mem_result`. A programmable grant delay lets benches stress the core's stall handling.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits. The RAM holds 2^ADDR_WIDTH 32-bit words at byte addresses 0 .. 4·2^ADDR_WIDTH−1.
- `GNT_DELAY`, default 0: number of idle cycles between first sight of `data_req_i` and `data_gnt_o`. Legal range 0..15.
- `FLAG_ADDR`, default 32'h0000_1000: byte address of the `mem_flag` register.
- `RESULT_ADDR`, default 32'h0000_1004: byte address of the `mem_result` register.

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `data_req_i` in 1: request; held with stable address/data until granted.
- `data_we_i` in 1: 1 = write, 0 = read.
- `data_be_i` in 4: byte enables for writes.
- `data_addr_i` in 32: byte address.
- `data_wdata_i` in 32: write data.
- `data_gnt_o` out 1: grant; 1-cycle pulse.
- `data_rvalid_o` out 1: response valid; 1-cycle pulse.
- `data_rdata_o` out 32: read data, valid while `data_rvalid_o` is 1.
- `data_err_o` out 1: error, qualified by `data_rvalid_o`.
- `mem_flag` out 32: flag register.
- `mem_result` out 32: result register.

## Operation
- FSM states: IDLE and WAIT.
  - IDLE with `data_req_i`=1: if `GNT_DELAY`=0, grant combinationally in the same cycle. Otherwise load counter = `GNT_DELAY` and go to WAIT.
  - WAIT: decrement the counter each cycle. When the counter reaches 0 with `data_req_i` still 1, assert `data_gnt_o` that cycle and return to IDLE.
  - `data_req_i` falling in WAIT (protocol violation): return to IDLE with no access and no response.
- Access decode at grant, latched for the response:
  - Address == `FLAG_ADDR` or `RESULT_ADDR` selects the corresponding register.
  - Otherwise, addresses below 4·2^ADDR_WIDTH select RAM word `data_addr_i[ADDR_WIDTH+1:2]`. Bits [1:0] are ignored.
  - Anything else is out of range.
- Writes take effect at the grant edge. Only bytes with `data_be_i[k]`=1 are updated. This applies to the RAM and to both registers.
- Reads:
  - `data_rdata_o` returns the full 32-bit word; byte-enables are ignored.
  - A register read returns its current value.
  - A RAM read returns the contents before any write granted in the same cycle.
- Out-of-range access: no state change; response has `data_err_o`=1 and `data_rdata_o`=0.
- Writes also produce an rvalid response; `data_rdata_o`=0 for writes.
- RAM contents are not reset. Testbenches may preload the RAM hierarchically through array `mem`.

## Timing
- Reset values: `data_gnt_o`=0, `data_rvalid_o`=0, `data_rdata_o`=0, `data_err_o`=0, `mem_flag`=0, `mem_result`=0, FSM=IDLE, counter=0.
- Latency:
  - Grant in cycle T gives `data_rvalid_o`=1 in T+1, always exactly one cycle later.
  - Request-to-grant is `GNT_DELAY` cycles; the grant is in the same cycle when `GNT_DELAY`=0.
- Back-to-back:
  - A new request may be granted in the same cycle as the previous rvalid. With `GNT_DELAY`=0, throughput is one access per cycle.
  - At most one response is ever outstanding.
- `mem_flag`/`mem_result` update on the grant edge and are visible the following cycle.
- Reset mid-operation: asserting `rst_ni` during WAIT or with an rvalid pending drops the transaction. No rvalid is produced after reset release.
- `data_rvalid_o` and `data_gnt_o` are never asserted while `rst_ni`=0.

## Test plan
- Reset: hold `rst_ni`=0 for 3 cycles with `data_req_i`=1.
  - All outputs must be 0 and no grant must occur.
  - After release, first grant at cycle 0 (`GNT_DELAY`=0).
- Write then read, `GNT_DELAY`=0:
  - Write 32'hDEAD_BEEF to 0x10 with be=4'hF, then read 0x10.
  - Required: gnt same cycle each time; rvalid next cycle; read returns 32'hDEAD_BEEF with err=0.
- Byte enables:
  - Write 32'h1122_3344 to 0x20 with be=4'hF, then write 32'hAABB_CCDD with be=4'b0101.
  - Read of 0x20 must return 32'h11BB_33DD.
- Grant delay, `GNT_DELAY`=3:
  - Hold req on a read of 0x0: gnt on the 4th cycle of req, rvalid on the 5th.
  - Drop req after 1 cycle on another read: no gnt and no rvalid.
- Status registers and error:
  - Write 32'd55 to `RESULT_ADDR`, then 32'd1 to `FLAG_ADDR`: `mem_result`=55, then `mem_flag`=1, each one cycle after its grant.
  - Read of 0x0000_2000: rvalid with err=1, rdata=0.
- Back-to-back: 8 consecutive reads of 0x0..0x1C with `GNT_DELAY`=0.
  - Required: 8 grants in 8 consecutive cycles, then 8 rvalids in the following 8 cycles, with data matching the preloaded words.

Source files
------------

// File: rtl/soc_data_mem.sv
// Data-side memory responder for the zero-riscy LSU: byte-enabled word RAM plus
// the mem_flag/mem_result status registers, with a programmable grant delay.
module soc_data_mem #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned GNT_DELAY   = 0,
  parameter logic [31:0] FLAG_ADDR   = 32'h0000_1000,
  parameter logic [31:0] RESULT_ADDR = 32'h0000_1004
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic [31:0] mem_flag,
  output logic [31:0] mem_result
);

  localparam logic [0:0]  STATE_IDLE = 1'b0;
  localparam logic [0:0]  STATE_WAIT = 1'b1;
  localparam logic [32:0] RAM_LIMIT  = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  DELAY_LOAD = 4'(GNT_DELAY);

  logic [31:0] mem [2**ADDR_WIDTH];

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt;
  logic [31:0] flag_q, flag_d;
  logic [31:0] result_q, result_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic                  sel_flag, sel_result, sel_ram;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           be_mask;

  // Grant sequencing: the counter expires on the cycle that carries the grant.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (data_req_i) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            cnt_d   = DELAY_LOAD;
            state_d = STATE_WAIT;
          end
        end
      end
      default: begin
        if (!data_req_i) begin
          cnt_d   = 4'd0;
          state_d = STATE_IDLE;
        end else if (cnt_q == 4'd1) begin
          gnt     = 1'b1;
          cnt_d   = 4'd0;
          state_d = STATE_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // Combinational grant must stay low while reset is held.
  assign data_gnt_o = gnt & rst_ni;

  assign sel_flag   = (data_addr_i == FLAG_ADDR);
  assign sel_result = !sel_flag && (data_addr_i == RESULT_ADDR);
  assign sel_ram    = !sel_flag && !sel_result && ({1'b0, data_addr_i} < RAM_LIMIT);
  assign word_idx   = data_addr_i[ADDR_WIDTH+1:2];

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      be_mask[8*k +: 8] = {8{data_be_i[k]}};
    end
  end

  // Access decode at the grant; the response is registered for the next cycle.
  always_comb begin
    rvalid_d = data_gnt_o;
    rdata_d  = 32'h0;
    err_d    = 1'b0;
    flag_d   = flag_q;
    result_d = result_q;
    if (data_gnt_o) begin
      if (sel_flag) begin
        if (data_we_i) flag_d = (flag_q & ~be_mask) | (data_wdata_i & be_mask);
        else           rdata_d = flag_q;
      end else if (sel_result) begin
        if (data_we_i) result_d = (result_q & ~be_mask) | (data_wdata_i & be_mask);
        else           rdata_d = result_q;
      end else if (sel_ram) begin
        if (!data_we_i) rdata_d = mem[word_idx];
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= STATE_IDLE;
      cnt_q    <= 4'd0;
      flag_q   <= 32'h0;
      result_q <= 32'h0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
      result_q <= result_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // RAM is deliberately not reset so benches can preload it.
  always_ff @(posedge clk_i) begin
    if (data_gnt_o && data_we_i && sel_ram) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
      end
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;
  assign mem_flag      = flag_q;
  assign mem_result    = result_q;

endmodule

// File: tb/tb_soc_data_mem.sv
// Bench for soc_data_mem: one instance with zero grant delay, one with a delay of 3.
module tb_soc_data_mem;

  logic        clk, rst_n;
  logic        req0, req3, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt0, rv0, err0, gnt3, rv3, err3;
  logic [31:0] rd0, flag0, res0, rd3, flag3, res3;

  int tests_run = 0;
  int tests_failed = 0;
  logic [32:0] exp_q[$];

  soc_data_mem #(.ADDR_WIDTH(10), .GNT_DELAY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req0), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt0), .data_rvalid_o(rv0),
    .data_rdata_o(rd0), .data_err_o(err0), .mem_flag(flag0), .mem_result(res0));

  soc_data_mem #(.ADDR_WIDTH(10), .GNT_DELAY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req3), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_gnt_o(gnt3), .data_rvalid_o(rv3),
    .data_rdata_o(rd3), .data_err_o(err3), .mem_flag(flag3), .mem_result(res3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pre(input int i);
    return 32'hC0DE_0000 + i * 32'h0001_0101;
  endfunction

  task automatic preload();
    for (int i = 0; i < 8; i++) begin
      dut0.mem[i] = pre(i);
      dut3.mem[i] = pre(i);
    end
  endtask

  // Drives one request on the selected instance and returns the grant cycle index (-1 on timeout).
  task automatic issue(input int sel, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d, output int wait_cyc);
    we = w; be = b; addr = a; wdata = d;
    if (sel == 0) req0 = 1'b1; else req3 = 1'b1;
    wait_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel == 0) ? gnt0 : gnt3) begin
        wait_cyc = i;
        @(posedge clk); #1;
        req0 = 1'b0; req3 = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req3 = 1'b0;
  endtask

  task automatic sample(input int sel, output logic rv, output logic [31:0] rd, output logic er);
    @(negedge clk);
    rv = (sel == 0) ? rv0 : rv3;
    rd = (sel == 0) ? rd0 : rd3;
    er = (sel == 0) ? err0 : err3;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [32:0] e;
    rst_n = 1'b0; req0 = 1'b1; req3 = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; wdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      tests_run++;
      if ({gnt0, rv0, err0, rd0, flag0, res0, gnt3, rv3, err3, rd3, flag3, res3} !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: gnt0=%b rv0=%b err0=%b rd0=%h flag0=%h res0=%h gnt3=%b rv3=%b, required all 0",
                 gnt0, rv0, err0, rd0, flag0, res0, gnt3, rv3);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req3 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (gnt0 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_first_gnt: gnt=%b required 1", gnt0);
    end else begin
      exp_q.push_back({1'b0, pre(0)});
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    tests_run++;
    if (rv0 !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL reset_first_rvalid: rvalid=%b required 1", rv0);
    end else begin
      e = exp_q.pop_front();
      if ({err0, rd0} !== e) begin
        tests_failed++;
        $display("FAIL reset_first_rdata: err=%b rdata=%h required err=%b rdata=%h", err0, rd0, e[32], e[31:0]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int wc; logic rv, er; logic [31:0] rd; logic [32:0] e;
    issue(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, wc);
    exp_q.push_back({1'b0, 32'h0});
    sample(0, rv, rd, er);
    tests_run++;
    if (wc !== 0 || rv !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_timing: gnt_cycle=%0d rvalid=%b required 0 and 1", wc, rv);
    end else begin
      e = exp_q.pop_front();
      if ({er, rd} !== e) begin
        tests_failed++;
        $display("FAIL wr_resp: err=%b rdata=%h required err=%b rdata=%h", er, rd, e[32], e[31:0]);
      end
    end
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, wc);
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    sample(0, rv, rd, er);
    tests_run++;
    if (wc !== 0 || rv !== 1'b1) begin
      tests_failed++;
      $display("FAIL rd_timing: gnt_cycle=%0d rvalid=%b required 0 and 1", wc, rv);
    end else begin
      e = exp_q.pop_front();
      if ({er, rd} !== e) begin
        tests_failed++;
        $display("FAIL rd_data: err=%b rdata=%h required err=%b rdata=%h", er, rd, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_byte_enables();
    int wc; logic rv, er; logic [31:0] rd; logic [32:0] e;
    issue(0, 1'b1, 4'hF, 32'h20, 32'h1122_3344, wc);
    sample(0, rv, rd, er);
    issue(0, 1'b1, 4'b0101, 32'h20, 32'hAABB_CCDD, wc);
    sample(0, rv, rd, er);
    issue(0, 1'b0, 4'h0, 32'h20, 32'h0, wc);
    exp_q.push_back({1'b0, 32'h11BB_33DD});
    sample(0, rv, rd, er);
    tests_run++;
    if (rv !== 1'b1) begin
      tests_failed++;
      $display("FAIL be_rvalid: rvalid=%b required 1", rv);
    end else begin
      e = exp_q.pop_front();
      if ({er, rd} !== e) begin
        tests_failed++;
        $display("FAIL be_data: err=%b rdata=%h required err=%b rdata=%h", er, rd, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_grant_delay();
    int wc; logic rv, er; logic [31:0] rd; logic [32:0] e; int seen;
    issue(3, 1'b0, 4'h0, 32'h0, 32'h0, wc);
    exp_q.push_back({1'b0, pre(0)});
    tests_run++;
    if (wc !== 3) begin
      tests_failed++;
      $display("FAIL delay_gnt_cycle: gnt on cycle index %0d required 3", wc);
    end
    sample(3, rv, rd, er);
    tests_run++;
    if (rv !== 1'b1) begin
      tests_failed++;
      $display("FAIL delay_rvalid: rvalid=%b required 1", rv);
    end else begin
      e = exp_q.pop_front();
      if ({er, rd} !== e) begin
        tests_failed++;
        $display("FAIL delay_data: err=%b rdata=%h required err=%b rdata=%h", er, rd, e[32], e[31:0]);
      end
    end
    exp_q.delete();
    we = 1'b0; addr = 32'h4; req3 = 1'b1;
    @(posedge clk); #1;
    req3 = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (gnt3 || rv3) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL delay_abort: %0d cycles with gnt/rvalid required 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_status_regs();
    int wc; logic rv, er; logic [31:0] rd; logic [32:0] e;
    issue(0, 1'b1, 4'hF, 32'h0000_1004, 32'd55, wc);
    @(negedge clk);
    tests_run++;
    if (res0 !== 32'd55 || flag0 !== 32'd0 || rv0 !== 1'b1 || rd0 !== 32'h0) begin
      tests_failed++;
      $display("FAIL result_reg: result=%0d flag=%0d rvalid=%b rdata=%h required 55 0 1 0", res0, flag0, rv0, rd0);
    end
    @(posedge clk); #1;
    issue(0, 1'b1, 4'hF, 32'h0000_1000, 32'd1, wc);
    @(negedge clk);
    tests_run++;
    if (flag0 !== 32'd1 || res0 !== 32'd55) begin
      tests_failed++;
      $display("FAIL flag_reg: flag=%0d result=%0d required 1 55", flag0, res0);
    end
    @(posedge clk); #1;
    issue(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0, wc);
    exp_q.push_back({1'b0, 32'd55});
    sample(0, rv, rd, er);
    tests_run++;
    if (rv !== 1'b1) begin
      tests_failed++;
      $display("FAIL result_read_rvalid: rvalid=%b required 1", rv);
    end else begin
      e = exp_q.pop_front();
      if ({er, rd} !== e) begin
        tests_failed++;
        $display("FAIL result_read: err=%b rdata=%h required err=%b rdata=%h", er, rd, e[32], e[31:0]);
      end
    end
    issue(0, 1'b0, 4'hF, 32'h0000_2000, 32'h0, wc);
    exp_q.push_back({1'b1, 32'h0});
    sample(0, rv, rd, er);
    tests_run++;
    if (rv !== 1'b1) begin
      tests_failed++;
      $display("FAIL oor_rvalid: rvalid=%b required 1", rv);
    end else begin
      e = exp_q.pop_front();
      if ({er, rd} !== e) begin
        tests_failed++;
        $display("FAIL oor_resp: err=%b rdata=%h required err=%b rdata=%h", er, rd, e[32], e[31:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int grants; int rvalids; logic [32:0] e;
    preload();
    grants = 0; rvalids = 0;
    we = 1'b0; be = 4'hF;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        addr = 32'(i * 4); req0 = 1'b1;
      end else begin
        req0 = 1'b0;
      end
      @(negedge clk);
      if (i < 8 && gnt0) begin
        grants++;
        exp_q.push_back({1'b0, pre(i)});
      end
      if (rv0) begin
        rvalids++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_resp: unexpected rvalid at step %0d", i);
        end else begin
          e = exp_q.pop_front();
          if ({err0, rd0} !== e) begin
            tests_failed++;
            $display("FAIL b2b_data: step=%0d err=%b rdata=%h required err=%b rdata=%h", i, err0, rd0, e[32], e[31:0]);
          end
        end
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (grants !== 8 || rvalids !== 8) begin
      tests_failed++;
      $display("FAIL b2b_count: grants=%0d rvalids=%0d required 8 8", grants, rvalids);
    end
    exp_q.delete();
  endtask

  initial begin
    req0 = 1'b0; req3 = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    rst_n = 1'b0;
    preload();
    test_reset();
    test_write_read();
    test_byte_enables();
    test_grant_delay();
    test_status_regs();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
